// File: rtl/alarm_ringer.sv
// Alarm ringer: rings on an alarm-match rising edge, supports snooze, stop and auto-timeout.
// Optional macro ALARM_RINGER_SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_ringer #(
   parameter int TIMEOUT_SEC = 60,
   parameter int SNOOZE_SEC  = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       secTick,
   input  logic       alarmOn,
   input  logic       alarmTrig,
   input  logic       snoozeButton,
   input  logic       stopButton,
   output logic       buzzer,
   output logic       ringLed,
   output logic [1:0] ringState,
   output logic [8:0] snoozeLeft,
   output logic [3:0] snoozeCnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2,
      DONE   = 2'd3
   } ring_state_t;

   localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_SEC - 1);
   localparam logic [8:0] SNOOZE_LOAD  = 9'(SNOOZE_SEC);

   ring_state_t state, state_n;
   logic        buzz_q, buzz_n;
   logic [8:0]  ring_sec, ring_sec_n;
   logic [8:0]  left_q, left_n;
   logic [3:0]  cnt_q, cnt_n;
   logic        trig_prev, snooze_prev, stop_prev;
   logic        primed;
   logic        trig_rise, snooze_rise, stop_rise;
   logic        snooze_allowed;
   logic [3:0]  cnt_inc;

   // Edges are ignored in the first cycle after reset so a trigger level that is
   // already high when reset releases is not mistaken for a new alarm.
   assign trig_rise   = primed & alarmTrig    & ~trig_prev;
   assign snooze_rise = primed & snoozeButton & ~snooze_prev;
   assign stop_rise   = primed & stopButton   & ~stop_prev;

   assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

`ifdef ALARM_RINGER_SNOOZE_LIMIT_EN
   localparam logic [3:0] SNOOZE_CAP = 4'(MAX_SNOOZE);
   assign snooze_allowed = (cnt_q != SNOOZE_CAP);
`else
   logic unused_max_snooze;
   assign unused_max_snooze = (MAX_SNOOZE > 0);
   assign snooze_allowed    = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         buzz_q      <= 1'b0;
         ring_sec    <= 9'd0;
         left_q      <= 9'd0;
         cnt_q       <= 4'd0;
         trig_prev   <= 1'b0;
         snooze_prev <= 1'b0;
         stop_prev   <= 1'b0;
         primed      <= 1'b0;
      end else begin
         state       <= state_n;
         buzz_q      <= buzz_n;
         ring_sec    <= ring_sec_n;
         left_q      <= left_n;
         cnt_q       <= cnt_n;
         trig_prev   <= alarmTrig;
         snooze_prev <= snoozeButton;
         stop_prev   <= stopButton;
         primed      <= 1'b1;
      end
   end

   // Switching the alarm off dominates everything; within RING, stop beats
   // timeout beats snooze beats the ordinary per-second beep toggle.
   always_comb begin
      state_n    = state;
      buzz_n     = buzz_q;
      ring_sec_n = ring_sec;
      left_n     = left_q;
      cnt_n      = cnt_q;

      if (!alarmOn) begin
         state_n    = IDLE;
         buzz_n     = 1'b0;
         ring_sec_n = 9'd0;
         left_n     = 9'd0;
         cnt_n      = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               buzz_n = 1'b0;
               if (trig_rise) begin
                  state_n    = RING;
                  ring_sec_n = 9'd0;
                  cnt_n      = 4'd0;
                  buzz_n     = 1'b1;
               end
            end
            RING: begin
               if (stop_rise || (secTick && ring_sec == TIMEOUT_LAST)) begin
                  state_n = DONE;
                  buzz_n  = 1'b0;
                  left_n  = 9'd0;
               end else if (snooze_rise && snooze_allowed) begin
                  state_n = SNOOZE;
                  left_n  = SNOOZE_LOAD;
                  cnt_n   = cnt_inc;
                  buzz_n  = 1'b0;
               end else if (secTick) begin
                  buzz_n     = ~buzz_q;
                  ring_sec_n = ring_sec + 9'd1;
               end
            end
            SNOOZE: begin
               buzz_n = 1'b0;
               if (stop_rise) begin
                  state_n = DONE;
                  left_n  = 9'd0;
               end else if (secTick) begin
                  if (left_q == 9'd1) begin
                     state_n    = RING;
                     ring_sec_n = 9'd0;
                     buzz_n     = 1'b1;
                     left_n     = 9'd0;
                  end else begin
                     left_n = left_q - 9'd1;
                  end
               end
            end
            DONE: begin
               buzz_n = 1'b0;
               left_n = 9'd0;
               if (!alarmTrig) begin
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
               buzz_n  = 1'b0;
            end
         endcase
      end
   end

   assign buzzer     = buzz_q;
   assign ringLed    = buzz_q;
   assign ringState  = state;
   assign snoozeLeft = left_q;
   assign snoozeCnt  = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer (TIMEOUT_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2).
// Expected outputs are queued per stimulus cycle and popped one cycle later.
module tb_alarm_ringer;

   logic       clk = 1'b0;
   logic       reset;
   logic       secTick;
   logic       alarmOn;
   logic       alarmTrig;
   logic       snoozeButton;
   logic       stopButton;
   logic       buzzer;
   logic       ringLed;
   logic [1:0] ringState;
   logic [8:0] snoozeLeft;
   logic [3:0] snoozeCnt;

   int vectors_applied = 0;
   int miscompares     = 0;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       bz;
      logic [8:0] sl;
      logic [3:0] sc;
   } exp_t;

   exp_t sb[$];

   alarm_ringer #(
      .TIMEOUT_SEC(4),
      .SNOOZE_SEC (3),
      .MAX_SNOOZE (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .secTick     (secTick),
      .alarmOn     (alarmOn),
      .alarmTrig   (alarmTrig),
      .snoozeButton(snoozeButton),
      .stopButton  (stopButton),
      .buzzer      (buzzer),
      .ringLed     (ringLed),
      .ringState   (ringState),
      .snoozeLeft  (snoozeLeft),
      .snoozeCnt   (snoozeCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
      vectors_applied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs they should produce, then
   // compare against the DUT just after the clock edge that registers them.
   task automatic applyStimulus(input string tag, input logic rst, input logic on, input logic trig,
                                input logic tick, input logic snz, input logic stp,
                                input logic [1:0] st, input logic bz, input logic [8:0] sl,
                                input logic [3:0] sc);
      exp_t e;
      reset        = rst;
      alarmOn      = on;
      alarmTrig    = trig;
      secTick      = tick;
      snoozeButton = snz;
      stopButton   = stp;
      e.tag = tag;
      e.st  = st;
      e.bz  = bz;
      e.sl  = sl;
      e.sc  = sc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checkOutput({e.tag, ".state"},  32'(ringState),  32'(e.st));
      checkOutput({e.tag, ".buzzer"}, 32'(buzzer),     32'(e.bz));
      checkOutput({e.tag, ".led"},    32'(ringLed),    32'(e.bz));
      checkOutput({e.tag, ".left"},   32'(snoozeLeft), 32'(e.sl));
      checkOutput({e.tag, ".cnt"},    32'(snoozeCnt),  32'(e.sc));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; alarmOn = 1'b0; alarmTrig = 1'b0;
      secTick = 1'b0; snoozeButton = 1'b0; stopButton = 1'b0;

      //              tag       rst on trg tk snz stp  st   bz sl   sc
      applyStimulus("reset",    1, 0, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("idle",     0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Ring to timeout, then release the trigger.
      applyStimulus("trig",     0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("tick1",    0, 1, 1, 1, 0, 0, 2'd1, 0, 9'd0, 4'd0);
      applyStimulus("tick2",    0, 1, 1, 1, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("tick3",    0, 1, 1, 1, 0, 0, 2'd1, 0, 9'd0, 4'd0);
      applyStimulus("timeout",  0, 1, 1, 1, 0, 0, 2'd3, 0, 9'd0, 4'd0);
      applyStimulus("donehold", 0, 1, 1, 0, 0, 0, 2'd3, 0, 9'd0, 4'd0);
      applyStimulus("trigoff",  0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Snooze countdown back into RING, with an ignored snooze edge.
      applyStimulus("trig2",    0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("rtick",    0, 1, 1, 1, 0, 0, 2'd1, 0, 9'd0, 4'd0);
      applyStimulus("snooze1",  0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd1);
      applyStimulus("sn_tk1",   0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd2, 4'd1);
      applyStimulus("sn_ign",   0, 1, 1, 1, 1, 0, 2'd2, 0, 9'd1, 4'd1);
      applyStimulus("sn_end",   0, 1, 1, 1, 0, 0, 2'd1, 1, 9'd0, 4'd1);

      // alarmOn drop during SNOOZE at snoozeLeft=2, then rise with trigger high.
      applyStimulus("snooze2",  0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd2);
      applyStimulus("sn_hold",  0, 1, 1, 0, 0, 0, 2'd2, 0, 9'd3, 4'd2);
      applyStimulus("sn_tk2",   0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd2, 4'd2);
      applyStimulus("alm_off",  0, 0, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("alm_on",   0, 1, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("trig_lo",  0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Two full snoozes, then a third snooze attempt.
      applyStimulus("t3",       0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("s1",       0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd1);
      applyStimulus("s1t1",     0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd2, 4'd1);
      applyStimulus("s1t2",     0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd1, 4'd1);
      applyStimulus("s1t3",     0, 1, 1, 1, 0, 0, 2'd1, 1, 9'd0, 4'd1);
      applyStimulus("s2",       0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd2);
      applyStimulus("s2t1",     0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd2, 4'd2);
      applyStimulus("s2t2",     0, 1, 1, 1, 0, 0, 2'd2, 0, 9'd1, 4'd2);
      applyStimulus("s2t3",     0, 1, 1, 1, 0, 0, 2'd1, 1, 9'd0, 4'd2);
`ifdef ALARM_RINGER_SNOOZE_LIMIT_EN
      applyStimulus("s3",       0, 1, 1, 0, 1, 0, 2'd1, 1, 9'd0, 4'd2);
      applyStimulus("s3hold",   0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd2);
`else
      applyStimulus("s3",       0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd3);
      applyStimulus("s3hold",   0, 1, 1, 0, 0, 0, 2'd2, 0, 9'd3, 4'd3);
`endif
      applyStimulus("off2",     0, 0, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("on2",      0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Stop and snooze in the same cycle: stop wins.
      applyStimulus("t4",       0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("t4tick",   0, 1, 1, 1, 0, 0, 2'd1, 0, 9'd0, 4'd0);
      applyStimulus("stop_snz", 0, 1, 1, 0, 1, 1, 2'd3, 0, 9'd0, 4'd0);
      applyStimulus("done_idl", 0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Reset mid-RING with the trigger held high.
      applyStimulus("t5",       0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("t5tick",   0, 1, 1, 1, 0, 0, 2'd1, 0, 9'd0, 4'd0);
      applyStimulus("rst_ring", 1, 1, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("post_rst", 0, 1, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("trig_hi",  0, 1, 1, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);
      applyStimulus("trig_lo2", 0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd0);

      // Stop from SNOOZE; the snooze count persists until the next alarm.
      applyStimulus("t6",       0, 1, 1, 0, 0, 0, 2'd1, 1, 9'd0, 4'd0);
      applyStimulus("t6snz",    0, 1, 1, 0, 1, 0, 2'd2, 0, 9'd3, 4'd1);
      applyStimulus("sn_stop",  0, 1, 1, 0, 0, 1, 2'd3, 0, 9'd0, 4'd1);
      applyStimulus("end_idle", 0, 1, 0, 0, 0, 0, 2'd0, 0, 9'd0, 4'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter TIMEOUT_SEC, default 60, seconds of ringing before auto-stop (1..511).
REQ-002 Parameter SNOOZE_SEC, default 300, snooze length in seconds (1..511).
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (1..15), used only under ALARM_RINGER_SNOOZE_LIMIT_EN.
REQ-004 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 secTick  input  1  one-cycle enable pulse, once per second.
REQ-007 alarmOn  input  1  alarm enable switch, level.
REQ-008 alarmTrig  input  1  alarm-match level from the alarm block, high for the matching minute.
REQ-009 snoozeButton  input  1  debounced level; acts on rising edge.
REQ-010 stopButton  input  1  debounced level; acts on rising edge.
REQ-011 buzzer  output  1  beep drive.
REQ-012 ringLed  output  1  equals buzzer.
REQ-013 ringState  output  2  IDLE=0, RING=1, SNOOZE=2, DONE=3.
REQ-014 snoozeLeft  output  9  remaining snooze seconds; 0 outside SNOOZE.
REQ-015 snoozeCnt  output  4  snoozes taken in the current alarm event.

Function
REQ-016 Rising edges SHALL be detected as input high and its registered previous value low; every decision SHALL be registered, so outputs reflect an event in cycle N at cycle N+1.
REQ-017 IDLE: alarmTrig rising edge with alarmOn=1 SHALL enter RING, clear ring-second counter, clear snoozeCnt, set buzzer=1.
REQ-018 RING: each secTick SHALL toggle buzzer and increment ring-second counter; secTick with counter==TIMEOUT_SEC-1 SHALL enter DONE.
REQ-019 RING: snooze edge SHALL enter SNOOZE, load snoozeLeft=SNOOZE_SEC, increment snoozeCnt (saturating at 15), clear buzzer.
REQ-020 SNOOZE: each secTick SHALL decrement snoozeLeft; secTick with snoozeLeft==1 SHALL enter RING with ring-second counter cleared, buzzer=1, snoozeLeft=0.
REQ-021 SNOOZE: snooze edges SHALL be ignored; alarmTrig edges SHALL be ignored.
REQ-022 RING or SNOOZE: stop edge SHALL enter DONE, buzzer=0, snoozeLeft=0.
REQ-023 Stop and snooze edges in the same cycle: stop SHALL win.
REQ-024 Stop edge and timeout in the same cycle: DONE (same result).
REQ-025 DONE: buzzer=0; SHALL return to IDLE in the cycle after alarmTrig is sampled low.
REQ-026 alarmOn=0 in any state SHALL force IDLE next cycle, buzzer=0, snoozeLeft=0, snoozeCnt=0; priority below reset, above all other events.
REQ-027 buzzer SHALL be 0 in every state except RING.
REQ-028 alarmTrig high at reset release or alarmOn rise SHALL NOT start ringing (no edge).

Reset
REQ-029 reset=1 SHALL give, next cycle: ringState=IDLE, buzzer=0, ringLed=0, snoozeLeft=0, snoozeCnt=0, counters and edge registers 0.
REQ-030 reset SHALL override every other input, including mid-RING and mid-SNOOZE.

Configuration
REQ-031 Macro ALARM_RINGER_SNOOZE_LIMIT_EN defined: snooze edge in RING with snoozeCnt==MAX_SNOOZE SHALL be ignored (ringing continues).
REQ-032 Macro undefined: snooze always accepted; snoozeCnt saturates at 15; MAX_SNOOZE unused.

Verification (TIMEOUT_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2)
REQ-033 alarmOn=1, alarmTrig 0->1 -> next cycle ringState=1, buzzer=1; after 4 secTicks ringState=3, buzzer=0; alarmTrig->0 -> ringState=0.
REQ-034 In RING, snooze edge -> ringState=2, snoozeLeft=3, snoozeCnt=1; ticks give 2,1, then ringState=1, buzzer=1.
REQ-035 Snooze and stop edges same cycle in RING -> ringState=3, snoozeCnt unchanged.
REQ-036 With macro: third snooze edge after two snoozes -> ringState stays 1, snoozeCnt=2; without macro -> ringState=2, snoozeCnt=3.
REQ-037 alarmOn->0 during SNOOZE with snoozeLeft=2 -> next cycle ringState=0, snoozeLeft=0, snoozeCnt=0.
REQ-038 reset pulse during RING -> next cycle all outputs 0; alarmTrig held high does not restart ringing.
